cv32e40p_x_result_wb: RTL and testbench
=======================================

// Module: cv32e40p_x_result_wb
// PURPOSE
//  Result-side companion of the X-interface dispatcher. Accepts coprocessor results on the
//  CORE-V-XIF result channel. Buffers them in a small in-order FIFO.
//  Drains them into the shared register-file write port whenever the core's own writeback is
//  idle. Each drained result also raises a scoreboard-release pulse so the dispatcher clears
//  the busy bit of rd.
// PARAMETERS
//  DEPTH      2    result FIFO entries; power of two, >= 2
//  ID_WIDTH   4    width of the XIF instruction id
// PORTS
//  clk_i               in   1         clock
//  rst_ni              in   1         reset, asynchronous, active-low
//  x_result_valid_i    in   1         coprocessor result valid
//  x_result_ready_o    out  1         result accepted this cycle when valid&ready
//  x_result_id_i       in   ID_WIDTH  id of the completing instruction
//  x_result_data_i     in   32        result data
//  x_result_rd_i       in   5         destination register
//  x_result_we_i       in   1         result must be written to rd
//  core_wb_busy_i      in   1         core pipeline owns the RF write port this cycle
//  rf_we_o             out  1         RF write enable (shared port, muxed outside)
//  rf_waddr_o          out  5         RF write address
//  rf_wdata_o          out  32        RF write data
//  sb_clr_valid_o      out  1         pulse: clear scoreboard bit sb_clr_rd_o
//  sb_clr_rd_o         out  5         register whose busy bit is released
//  last_id_o           out  ID_WIDTH  id of the most recently retired result
//  pending_o           out  $clog2(DEPTH)+1  results buffered, not yet written
// BEHAVIOUR
//  - Reset: FIFO empty, pointers/count 0, last_id_o=0.
//    rf_we_o=0, sb_clr_valid_o=0, rf_waddr_o=0, rf_wdata_o=0, sb_clr_rd_o=0.
//    x_result_ready_o=1 (combinational ~full).
//  - Handshake: x_result_ready_o = (count != DEPTH). No combinational dependency on valid
//    or core_wb_busy_i. A valid result must be held stable until ready is high.
//  - Retire condition: ~core_wb_busy_i, plus either
//    (a) FIFO non-empty, which pops the head, or
//    (b) FIFO empty and an accepted result, which bypasses with 0-cycle latency and no push.
//  - Bypass is only allowed when the FIFO is empty; strict in-order retirement always holds.
//  - Accepted result that does not retire this cycle: pushed at wr_ptr. Latency >= 1 cycle.
//  - Simultaneous pop and push: count unchanged, both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap naturally.
//  - When full with a pop in the same cycle: ready stays 0 that cycle, with no same-cycle
//    refill (avoids a busy->ready path).
//  - On retire of entry E (comb outputs, same cycle):
//    - rf_we_o   = E.we & (E.rd != 0); rf_waddr_o = E.rd; rf_wdata_o = E.data.
//    - sb_clr_valid_o = E.we; sb_clr_rd_o = E.rd. A we=0 result retires silently.
//    - last_id_o <= E.id at the next edge.
//  - When not retiring: rf_we_o=0 and sb_clr_valid_o=0. Address/data outputs are don't-care
//    and driven 0.
//  - core_wb_busy_i high: nothing retires. The FIFO keeps accepting until full, then
//    backpressures. Stall is unbounded; no entry is lost or reordered.
//  - Reset mid-operation discards all buffered results. The dispatcher scoreboard resets in
//    the same way, so no stale busy bits remain.
//  - pending_o = count (excludes a bypassed result).
// TESTING
//  - Bypass: busy=0, valid rd=5 data=0xA5A5_0001 we=1 -> same cycle rf_we=1 waddr=5,
//    sb_clr rd=5, pending=0.
//  - Buffer+drain: busy=1, 2 results rd=3 then rd=7 -> ready=0 after 2nd, pending=2.
//    Busy=0 -> rd=3 written then rd=7 on consecutive cycles, ready returns to 1.
//  - Order under mix: FIFO holds 1 entry, busy=0, new valid arrives -> head pops, new one is
//    pushed (no bypass), retires next cycle.
//  - x0/we=0: rd=0 we=1 -> rf_we=0, sb_clr_valid=1. rd=9 we=0 -> rf_we=0, sb_clr_valid=0,
//    last_id updates.
//  - Wrap: 3*DEPTH results with busy toggling randomly -> all written exactly once, in id
//    order, count never exceeds DEPTH.
//  - Reset with pending=2 -> next cycle pending=0, ready=1, no rf_we/sb_clr pulses.

Source files
------------

// File: rtl/cv32e40p_x_result_wb.sv
// -----------------------------------------------------------------------------
// cv32e40p_x_result_wb
//
// Result-side companion of the X-interface dispatcher. Coprocessor results
// arrive on the CORE-V-XIF result channel, are buffered in a small in-order
// FIFO and drained into the shared register-file write port whenever the
// core's own writeback is idle. Every retired result also pulses a
// scoreboard release so the dispatcher can clear the busy bit of rd.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   x_result_*           XIF result channel (valid/ready handshake + payload)
//   core_wb_busy_i       core pipeline owns the RF write port this cycle
//   rf_we_o/waddr/wdata  RF write port request (muxed outside)
//   sb_clr_valid_o/rd_o  scoreboard busy-bit release pulse
//   last_id_o            id of the most recently retired result
//   pending_o            number of results buffered but not yet written
// -----------------------------------------------------------------------------
module cv32e40p_x_result_wb #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       x_result_valid_i,
  output logic                       x_result_ready_o,
  input  logic [ID_WIDTH-1:0]        x_result_id_i,
  input  logic [31:0]                x_result_data_i,
  input  logic [4:0]                 x_result_rd_i,
  input  logic                       x_result_we_i,
  input  logic                       core_wb_busy_i,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_waddr_o,
  output logic [31:0]                rf_wdata_o,
  output logic                       sb_clr_valid_o,
  output logic [4:0]                 sb_clr_rd_o,
  output logic [ID_WIDTH-1:0]        last_id_o,
  output logic [$clog2(DEPTH):0]     pending_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                we;
    logic [4:0]          rd;
    logic [31:0]         data;
  } entry_t;

  entry_t [DEPTH-1:0]  mem_q,     mem_d;
  logic   [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic   [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic   [CNT_W-1:0]  count_q,   count_d;
  logic [ID_WIDTH-1:0] last_id_q, last_id_d;

  logic   accept, empty, pop, bypass, push, retire;
  entry_t in_entry, ret_entry;

  // Ready depends only on the fill level, so a full FIFO that pops this cycle
  // still refuses input; this keeps core_wb_busy_i off the ready path.
  assign x_result_ready_o = (count_q != CNT_W'(DEPTH));
  assign empty            = (count_q == '0);
  assign accept           = x_result_valid_i & x_result_ready_o;

  assign in_entry = '{id: x_result_id_i, we: x_result_we_i,
                      rd: x_result_rd_i, data: x_result_data_i};

  // Bypass only from an empty FIFO, which keeps retirement strictly in order.
  always_comb begin
    pop       = ~core_wb_busy_i & ~empty;
    bypass    = ~core_wb_busy_i & empty & accept;
    push      = accept & ~bypass;
    retire    = pop | bypass;
    ret_entry = pop ? mem_q[rd_ptr_q] : in_entry;
  end

  // Retire outputs; address/data are zeroed when idle. Writes to x0 are
  // suppressed but still release the scoreboard bit.
  always_comb begin
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    sb_clr_valid_o = 1'b0;
    sb_clr_rd_o    = '0;
    if (retire) begin
      rf_we_o        = ret_entry.we & (ret_entry.rd != 5'd0);
      rf_waddr_o     = ret_entry.rd;
      rf_wdata_o     = ret_entry.data;
      sb_clr_valid_o = ret_entry.we;
      sb_clr_rd_o    = ret_entry.rd;
    end
  end

  // Next-state for storage, pointers, fill count and last retired id.
  // Pointers are exactly log2(DEPTH) bits wide and wrap on their own.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_id_d = last_id_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (retire) begin
      last_id_d = ret_entry.id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_id_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_id_q <= last_id_d;
    end
  end

  assign last_id_o = last_id_q;
  assign pending_o = count_q;

endmodule

// File: tb/tb_cv32e40p_x_result_wb.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_x_result_wb
//
// Self-checking bench for cv32e40p_x_result_wb. A queue-based reference
// model tracks buffered results and predicts each cycle's handshake, retire
// outputs, fill level and last retired id.
// -----------------------------------------------------------------------------
module tb_cv32e40p_x_result_wb;

  localparam int DEPTH = 2;
  localparam int IDW   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk_i;
  logic            rst_ni;
  logic            x_result_valid_i;
  logic            x_result_ready_o;
  logic [IDW-1:0]  x_result_id_i;
  logic [31:0]     x_result_data_i;
  logic [4:0]      x_result_rd_i;
  logic            x_result_we_i;
  logic            core_wb_busy_i;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [31:0]     rf_wdata_o;
  logic            sb_clr_valid_o;
  logic [4:0]      sb_clr_rd_o;
  logic [IDW-1:0]  last_id_o;
  logic [CW-1:0]   pending_o;

  cv32e40p_x_result_wb #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_id_i    (x_result_id_i),
    .x_result_data_i  (x_result_data_i),
    .x_result_rd_i    (x_result_rd_i),
    .x_result_we_i    (x_result_we_i),
    .core_wb_busy_i   (core_wb_busy_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .sb_clr_valid_o   (sb_clr_valid_o),
    .sb_clr_rd_o      (sb_clr_rd_o),
    .last_id_o        (last_id_o),
    .pending_o        (pending_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic [4:0]     rd;
    logic           we;
  } res_t;

  res_t           modelQ[$];
  logic [IDW-1:0] modelLastId;
  logic [IDW-1:0] issuedIds[$];
  logic [IDW-1:0] retiredIds[$];
  int             errors = 0;
  int             checks = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs (called just after a falling edge), checks
  // the combinational outputs against the model before the rising edge,
  // then advances the model across that edge.
  task automatic applyStimulus(input logic v, input logic [IDW-1:0] id,
                               input logic [31:0] d, input logic [4:0] rd,
                               input logic we, input logic busy);
    logic expReady, acc, ret, fromQ, byp;
    res_t inRes, e;
    x_result_valid_i = v;
    x_result_id_i    = id;
    x_result_data_i  = d;
    x_result_rd_i    = rd;
    x_result_we_i    = we;
    core_wb_busy_i   = busy;
    #1;
    inRes    = '{id: id, data: d, rd: rd, we: we};
    expReady = (modelQ.size() != DEPTH);
    acc      = v && expReady;
    ret = 1'b0; fromQ = 1'b0; byp = 1'b0;
    e   = '{id: '0, data: '0, rd: '0, we: 1'b0};
    if (!busy) begin
      if (modelQ.size() > 0) begin
        e = modelQ[0]; ret = 1'b1; fromQ = 1'b1;
      end else if (acc) begin
        e = inRes; ret = 1'b1; byp = 1'b1;
      end
    end
    checkOutput("ready",    64'(x_result_ready_o), 64'(expReady));
    checkOutput("rf_we",    64'(rf_we_o),          64'(ret && e.we && (e.rd != 0)));
    checkOutput("sb_clr",   64'(sb_clr_valid_o),   64'(ret && e.we));
    checkOutput("waddr",    64'(rf_waddr_o),       64'(ret ? e.rd : 5'd0));
    checkOutput("wdata",    64'(rf_wdata_o),       64'(ret ? e.data : 32'd0));
    checkOutput("sb_rd",    64'(sb_clr_rd_o),      64'(ret ? e.rd : 5'd0));
    checkOutput("pending",  64'(pending_o),        64'(modelQ.size()));
    checkOutput("last_id",  64'(last_id_o),        64'(modelLastId));
    checkOutput("cnt_le_d", 64'(pending_o <= DEPTH), 64'(1));
    @(posedge clk_i);
    if (fromQ) void'(modelQ.pop_front());
    if (acc && !byp) modelQ.push_back(inRes);
    if (ret) begin
      modelLastId = e.id;
      retiredIds.push_back(e.id);
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input logic busy);
    applyStimulus(1'b0, '0, 32'd0, 5'd0, 1'b0, busy);
  endtask

  logic           cv, cwe, busyR, hold, acc;
  logic [IDW-1:0] cid, nextId;
  logic [31:0]    cd;
  logic [4:0]     crd;

  initial begin
    rst_ni = 1'b0;
    x_result_valid_i = 1'b0; x_result_id_i = '0; x_result_data_i = '0;
    x_result_rd_i = '0; x_result_we_i = 1'b0; core_wb_busy_i = 1'b0;
    modelLastId = '0;
    #12;
    checkOutput("rst_ready",   64'(x_result_ready_o), 64'(1));
    checkOutput("rst_rf_we",   64'(rf_we_o),          64'(0));
    checkOutput("rst_pending", 64'(pending_o),        64'(0));
    checkOutput("rst_last_id", 64'(last_id_o),        64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Bypass from an empty FIFO: written in the same cycle
    x_result_valid_i = 1'b1; x_result_id_i = 4'd1; x_result_data_i = 32'hA5A5_0001;
    x_result_rd_i = 5'd5; x_result_we_i = 1'b1; core_wb_busy_i = 1'b0;
    #1;
    checkOutput("byp_rf_we", 64'(rf_we_o),    64'(1));
    checkOutput("byp_waddr", 64'(rf_waddr_o), 64'(5));
    checkOutput("byp_pend",  64'(pending_o),  64'(0));
    applyStimulus(1'b1, 4'd1, 32'hA5A5_0001, 5'd5, 1'b1, 1'b0);

    // Buffer two results while busy, then drain in order
    applyStimulus(1'b1, 4'd2, 32'h0000_0033, 5'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'd3, 32'h0000_0077, 5'd7, 1'b1, 1'b1);
    #1;
    checkOutput("full_ready", 64'(x_result_ready_o), 64'(0));
    checkOutput("full_pend",  64'(pending_o),        64'(2));
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // One entry held, new result arrives as busy drops: pop head, push new
    applyStimulus(1'b1, 4'd4, 32'h1111_0004, 5'd4, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'd5, 32'h1111_0005, 5'd6, 1'b1, 1'b0);
    idle(1'b0);

    // x0 target and a we=0 result
    applyStimulus(1'b1, 4'd6, 32'hDEAD_0000, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd7, 32'hBEEF_0009, 5'd9, 1'b0, 1'b0);
    idle(1'b0);
    checkOutput("we0_last_id", 64'(last_id_o), 64'(7));

    // Randomised traffic with valid held until accepted
    issuedIds.delete();
    retiredIds.delete();
    nextId = 4'd8;
    hold   = 1'b0;
    cv = 1'b0; cid = '0; cd = '0; crd = '0; cwe = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (!hold) begin
        cv = ($urandom_range(0, 2) != 0);
        if (cv) begin
          cid = nextId;
          cd  = $urandom;
          crd = 5'($urandom_range(0, 31));
          cwe = ($urandom_range(0, 3) != 0);
        end
      end
      busyR = ($urandom_range(0, 1) != 0);
      acc   = cv && (modelQ.size() != DEPTH);
      if (acc) begin
        issuedIds.push_back(cid);
        nextId = nextId + 4'd1;
      end
      hold = cv && !acc;
      applyStimulus(cv, cid, cd, crd, cwe, busyR);
    end
    for (int i = 0; i < 4 * DEPTH && modelQ.size() > 0; i++) idle(1'b0);
    #1;
    checkOutput("drained", 64'(pending_o), 64'(0));
    checkOutput("ret_count", 64'(retiredIds.size()), 64'(issuedIds.size()));
    for (int i = 0; i < issuedIds.size() && i < retiredIds.size(); i++)
      checkOutput($sformatf("order%0d", i), 64'(retiredIds[i]), 64'(issuedIds[i]));

    // Reset while two results are pending
    applyStimulus(1'b1, 4'hA, 32'h0000_00AA, 5'd10, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'hB, 32'h0000_00BB, 5'd11, 1'b1, 1'b1);
    #1;
    checkOutput("pre_rst_pend", 64'(pending_o), 64'(2));
    x_result_valid_i = 1'b0; core_wb_busy_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    modelQ.delete();
    modelLastId = '0;
    checkOutput("mid_rst_pend",  64'(pending_o),        64'(0));
    checkOutput("mid_rst_ready", 64'(x_result_ready_o), 64'(1));
    checkOutput("mid_rst_rf_we", 64'(rf_we_o),          64'(0));
    checkOutput("mid_rst_sb",    64'(sb_clr_valid_o),   64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
